vx_fetch_stage: RTL and testbench
=================================

// Module: vx_fetch_stage
// PURPOSE
//  Consumes the warp scheduler's schedule handshake {uuid, wid, tmask, PC}, issues the I-cache read and holds per-warp
//  metadata while the read is in flight. On the I-cache response it emits {uuid, wid, tmask, PC, instr} to decode.
//  Sits between the scheduler and the decode stage. Allows one outstanding fetch per warp and out-of-order responses.
// PARAMETERS
//  NUM_WARPS      `NUM_WARPS    warps tracked; NW_W = `LOG2UP(NUM_WARPS)
//  THREAD_CNT     `NUM_THREADS  tmask width
//  TAG_W          `UUID_WIDTH+NW_W  I-cache tag width; tag = {uuid, wid}
//  PERF_CTR_BITS  44            width of perf_stall_cycles
// PORTS
//  clk                in   1          clock
//  reset              in   1          synchronous, active-high
//  sched_valid        in   1          schedule request valid
//  sched_uuid         in   UUID_WIDTH instruction uuid
//  sched_wid          in   NW_W       warp id
//  sched_tmask        in   THREAD_CNT thread mask
//  sched_PC           in   XLEN       fetch PC, 4-byte aligned
//  sched_ready        out  1          schedule accepted when valid & ready
//  icache_req_valid   out  1          I-cache read request
//  icache_req_addr    out  XLEN-2     word address = sched_PC[XLEN-1:2]
//  icache_req_tag     out  TAG_W      {sched_uuid, sched_wid}
//  icache_req_ready   in   1          I-cache can accept
//  icache_rsp_valid   in   1          I-cache response valid
//  icache_rsp_data    in   32         instruction word
//  icache_rsp_tag     in   TAG_W      echoed tag
//  icache_rsp_ready   out  1          response consumed
//  fetch_valid        out  1          to decode
//  fetch_uuid         out  UUID_WIDTH from rsp tag
//  fetch_wid          out  NW_W       from rsp tag
//  fetch_tmask        out  THREAD_CNT from tag table
//  fetch_PC           out  XLEN       from tag table
//  fetch_instr        out  32         icache_rsp_data
//  fetch_ready        in   1          decode accepts
//  busy               out  1          |pending
//  perf_stall_cycles  out  PERF_CTR_BITS  see CONFIGURATION
// BEHAVIOUR
//  - State: pending[NUM_WARPS] (reset 0); tag table of {tmask, PC} per wid (no reset, written only on accept).
//  - Issue, combinational, zero latency:
//      icache_req_valid = sched_valid & ~pending[sched_wid]
//      sched_ready      = icache_req_ready & ~pending[sched_wid]
//  - Accept (sched_valid & sched_ready): next cycle pending[wid]=1 and table[wid]={tmask, PC}.
//  - Response, combinational pass-through; hit = pending[rsp wid]:
//      fetch_valid      = icache_rsp_valid & hit
//      icache_rsp_ready = hit ? fetch_ready : 1
//  - Miss (non-pending wid): response is dropped and flagged by a simulation assertion.
//  - fetch_valid & fetch_ready clears pending[wid] next cycle. Outputs hold stable while fetch_valid & ~fetch_ready.
//  - The same-cycle response and new schedule for the same wid are not both accepted: the schedule sees the registered
//    pending and stalls one cycle. Different wids proceed in parallel, so an accept and a clear can occur in the same
//    cycle.
//  - All NUM_WARPS pending: sched_ready=0 for every wid. busy=1.
//  - Reset outputs: sched_ready=0, icache_req_valid=0, icache_rsp_ready=1, fetch_valid=0, busy=0, perf_stall_cycles=0.
//  - Reset mid-operation clears pending. Late responses are then dropped as misses.
//  - sched_PC[1:0] != 0 is an assertion error. The low bits are ignored in the address, and fetch_PC returns the full
//    stored PC.
// CONFIGURATION
//  VX_FETCH_PERF_EN defined:
//    perf_stall_cycles += 1 each cycle with sched_valid & ~sched_ready. Saturates at all-ones.
//  VX_FETCH_PERF_EN undefined:
//    perf_stall_cycles tied to 0 and no counter flops are built.
// STRUCTURE
//  - Package VX_fetch_pkg: fetch_tag_t {uuid, wid} and fetch_entry_t {tmask, PC}.
//  - One sub-module, vx_fetch_tag_table: pending bits plus the entry array, with a write port, a clear port, and async
//    read by wid.
// TESTING
//  1. Single fetch: wid=1, PC=0x80000000, tmask=4'b1111, rsp data 0x00000013 -> fetch shows all fields; busy is 1 then 0.
//  2. Out-of-order: issue wid0 then wid2, respond wid2 then wid0 -> each fetch carries its own PC and tmask.
//  3. Same-warp hazard: second schedule for wid3 while pending -> sched_ready=0 until the cycle after the fetch handshake.
//  4. Backpressure: fetch_ready=0 for 5 cycles -> icache_rsp_ready=0 and outputs stable. Release gives a single handshake.
//  5. Reset with 2 fetches pending, then stale responses -> both dropped, fetch_valid=0, busy=0.
//  6. VX_FETCH_PERF_EN: icache_req_ready=0 for 7 cycles with sched_valid=1 -> perf_stall_cycles=7. Without the macro -> 0.

Source files
------------

// File: rtl/VX_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : VX_fetch_pkg
//  Description : Shared widths and types for the instruction fetch stage.
//                Widths NUM_WARPS, NUM_THREADS, UUID_WIDTH and XLEN are
//                fixed package parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package VX_fetch_pkg;

    localparam int NUM_WARPS   = 4;
    localparam int NUM_THREADS = 4;
    localparam int UUID_WIDTH  = 44;
    localparam int XLEN        = 32;

    // Warp-id width, never narrower than one bit.
    localparam int NW_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int TAG_W = UUID_WIDTH + NW_W;

    // I-cache tag: uuid in the upper bits, warp id in the lower bits.
    typedef struct packed {
        logic [UUID_WIDTH-1:0] uuid;
        logic [NW_W-1:0]       wid;
    } fetch_tag_t;

    // Per-warp metadata held while the I-cache read is in flight.
    typedef struct packed {
        logic [NUM_THREADS-1:0] tmask;
        logic [XLEN-1:0]        PC;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/vx_fetch_tag_table.sv
`default_nettype none
// ============================================================================
//  Module      : vx_fetch_tag_table
//  Description : One pending bit and one {tmask, PC} entry per warp. Write
//                port sets pending and stores the entry; clear port drops
//                pending. Entry read is asynchronous by warp id.
//  Revision    : 1.0 - initial release
// ============================================================================
module vx_fetch_tag_table
   import VX_fetch_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 wr_en,
   input  logic [NW_W-1:0]                      wr_wid,
   input  logic [$bits(fetch_entry_t)-1:0]      wr_entry,
   input  logic                                 clr_en,
   input  logic [NW_W-1:0]                      clr_wid,
   input  logic [NW_W-1:0]                      rd_wid,
   output logic [$bits(fetch_entry_t)-1:0]      rd_entry,
   output logic [NUM_WARPS-1:0]                 pending
);

   logic [NUM_WARPS-1:0]             pending_bits;
   logic [$bits(fetch_entry_t)-1:0]  entries [NUM_WARPS];

   // Pending bits: clear and set target different warps, so ordering only
   // matters for robustness; set wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_bits <= '0;
      end else begin
         if (clr_en) pending_bits[clr_wid] <= 1'b0;
         if (wr_en)  pending_bits[wr_wid]  <= 1'b1;
      end
   end

   // Entry storage has no reset; it is only meaningful while pending.
   always_ff @(posedge clk) begin
      if (wr_en) entries[wr_wid] <= wr_entry;
   end

   assign rd_entry = entries[rd_wid];
   assign pending  = pending_bits;

endmodule
`default_nettype wire

// File: rtl/vx_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : vx_fetch_stage
//  Description : Accepts schedule requests, issues I-cache reads tagged with
//                {uuid, wid}, and joins out-of-order responses with the stored
//                {tmask, PC} to feed decode. One outstanding fetch per warp.
//                Optional macro VX_FETCH_PERF_EN builds a saturating
//                schedule-stall cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module vx_fetch_stage
   import VX_fetch_pkg::*;
#(
   parameter int PERF_CTR_BITS = 44
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sched_valid,
   input  logic [UUID_WIDTH-1:0]    sched_uuid,
   input  logic [NW_W-1:0]          sched_wid,
   input  logic [NUM_THREADS-1:0]   sched_tmask,
   input  logic [XLEN-1:0]          sched_PC,
   output logic                     sched_ready,
   output logic                     icache_req_valid,
   output logic [XLEN-3:0]          icache_req_addr,
   output logic [TAG_W-1:0]         icache_req_tag,
   input  logic                     icache_req_ready,
   input  logic                     icache_rsp_valid,
   input  logic [31:0]              icache_rsp_data,
   input  logic [TAG_W-1:0]         icache_rsp_tag,
   output logic                     icache_rsp_ready,
   output logic                     fetch_valid,
   output logic [UUID_WIDTH-1:0]    fetch_uuid,
   output logic [NW_W-1:0]          fetch_wid,
   output logic [NUM_THREADS-1:0]   fetch_tmask,
   output logic [XLEN-1:0]          fetch_PC,
   output logic [31:0]              fetch_instr,
   input  logic                     fetch_ready,
   output logic                     busy,
   output logic [PERF_CTR_BITS-1:0] perf_stall_cycles
);

   fetch_tag_t           req_tag;
   fetch_tag_t           rsp_tag;
   fetch_entry_t         wr_entry;
   fetch_entry_t         rd_entry;
   logic [NUM_WARPS-1:0] pending;
   logic                 sched_blocked;
   logic                 hit;
   logic                 sched_fire;
   logic                 fetch_fire;

   // Schedule side: a warp with a fetch in flight is held off. Reset also
   // blocks so nothing is issued while the pending bits are being cleared.
   assign sched_blocked    = reset | pending[sched_wid];
   assign icache_req_valid = sched_valid & ~sched_blocked;
   assign sched_ready      = icache_req_ready & ~sched_blocked;
   assign sched_fire       = sched_valid & sched_ready;

   assign req_tag.uuid     = sched_uuid;
   assign req_tag.wid      = sched_wid;
   assign icache_req_tag   = req_tag;
   assign icache_req_addr  = sched_PC[XLEN-1:2];

   assign wr_entry.tmask   = sched_tmask;
   assign wr_entry.PC      = sched_PC;

   // Response side: pass-through when the tagged warp is pending, otherwise
   // the response is swallowed (ready=1, no fetch_valid).
   assign rsp_tag          = icache_rsp_tag;
   assign hit              = pending[rsp_tag.wid] & ~reset;
   assign fetch_valid      = icache_rsp_valid & hit;
   assign icache_rsp_ready = hit ? fetch_ready : 1'b1;
   assign fetch_fire       = fetch_valid & fetch_ready;

   assign fetch_uuid       = rsp_tag.uuid;
   assign fetch_wid        = rsp_tag.wid;
   assign fetch_tmask      = rd_entry.tmask;
   assign fetch_PC         = rd_entry.PC;
   assign fetch_instr      = icache_rsp_data;

   assign busy             = (|pending) & ~reset;

   vx_fetch_tag_table u_tag_table (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (sched_fire),
      .wr_wid   (sched_wid),
      .wr_entry (wr_entry),
      .clr_en   (fetch_fire),
      .clr_wid  (rsp_tag.wid),
      .rd_wid   (rsp_tag.wid),
      .rd_entry (rd_entry),
      .pending  (pending)
   );

`ifdef VX_FETCH_PERF_EN
   logic [PERF_CTR_BITS-1:0] stall_count;

   // Count cycles where the scheduler offers work but cannot issue; saturate.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (sched_valid && !sched_ready && !(&stall_count)) begin
         stall_count <= stall_count + PERF_CTR_BITS'(1);
      end
   end

   assign perf_stall_cycles = stall_count;
`else
   assign perf_stall_cycles = '0;
`endif

`ifndef SYNTHESIS
   // Scheduled PCs must be word aligned.
   always_ff @(posedge clk) begin
      if (!reset && sched_valid) begin
         assert (sched_PC[1:0] == 2'b00)
            else $error("vx_fetch_stage: unaligned sched_PC 0x%0h", sched_PC);
      end
   end

   // A response for an idle warp is dropped; flag it for debug.
   always_ff @(posedge clk) begin
      if (!reset && icache_rsp_valid) begin
         assert (hit)
            else $warning("vx_fetch_stage: response for idle warp %0d dropped", rsp_tag.wid);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vx_fetch_stage
//  Description : Directed scenarios plus randomized traffic for
//                vx_fetch_stage against a per-warp record model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_fetch_stage;
   import VX_fetch_pkg::*;

   localparam int PCB = 44;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   sched_valid = 1'b0;
   logic [UUID_WIDTH-1:0]  sched_uuid = '0;
   logic [NW_W-1:0]        sched_wid = '0;
   logic [NUM_THREADS-1:0] sched_tmask = '0;
   logic [XLEN-1:0]        sched_PC = '0;
   logic                   sched_ready;
   logic                   icache_req_valid;
   logic [XLEN-3:0]        icache_req_addr;
   logic [TAG_W-1:0]       icache_req_tag;
   logic                   icache_req_ready = 1'b1;
   logic                   icache_rsp_valid = 1'b0;
   logic [31:0]            icache_rsp_data = '0;
   logic [UUID_WIDTH-1:0]  rsp_uuid = '0;
   logic [NW_W-1:0]        rsp_wid = '0;
   logic                   icache_rsp_ready;
   logic                   fetch_valid;
   logic [UUID_WIDTH-1:0]  fetch_uuid;
   logic [NW_W-1:0]        fetch_wid;
   logic [NUM_THREADS-1:0] fetch_tmask;
   logic [XLEN-1:0]        fetch_PC;
   logic [31:0]            fetch_instr;
   logic                   fetch_ready = 1'b1;
   logic                   busy;
   logic [PCB-1:0]         perf_stall_cycles;

   always #5 clk = ~clk;

   vx_fetch_stage #(.PERF_CTR_BITS(PCB)) dut (
      .clk               (clk),
      .reset             (reset),
      .sched_valid       (sched_valid),
      .sched_uuid        (sched_uuid),
      .sched_wid         (sched_wid),
      .sched_tmask       (sched_tmask),
      .sched_PC          (sched_PC),
      .sched_ready       (sched_ready),
      .icache_req_valid  (icache_req_valid),
      .icache_req_addr   (icache_req_addr),
      .icache_req_tag    (icache_req_tag),
      .icache_req_ready  (icache_req_ready),
      .icache_rsp_valid  (icache_rsp_valid),
      .icache_rsp_data   (icache_rsp_data),
      .icache_rsp_tag    ({rsp_uuid, rsp_wid}),
      .icache_rsp_ready  (icache_rsp_ready),
      .fetch_valid       (fetch_valid),
      .fetch_uuid        (fetch_uuid),
      .fetch_wid         (fetch_wid),
      .fetch_tmask       (fetch_tmask),
      .fetch_PC          (fetch_PC),
      .fetch_instr       (fetch_instr),
      .fetch_ready       (fetch_ready),
      .busy              (busy),
      .perf_stall_cycles (perf_stall_cycles)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: each warp either has an in-flight record or not.
   bit                     m_busy_warp [NUM_WARPS];
   logic [XLEN-1:0]        m_pc        [NUM_WARPS];
   logic [NUM_THREADS-1:0] m_tm        [NUM_WARPS];
   logic [UUID_WIDTH-1:0]  m_uuid      [NUM_WARPS];
   longint unsigned        m_perf = 0;

   // Check every output against the model, cross one clock edge, update model.
   task automatic tick();
      bit e_req, e_rdy, e_fv, e_rr, e_busy, e_hit;
      longint unsigned e_perf;
      #1;
      e_busy = 1'b0;
      foreach (m_busy_warp[i]) e_busy |= m_busy_warp[i];
      if (reset) begin
         e_req = 0; e_rdy = 0; e_fv = 0; e_rr = 1; e_busy = 0; e_hit = 0;
      end else begin
         e_req = sched_valid && !m_busy_warp[sched_wid];
         e_rdy = icache_req_ready && !m_busy_warp[sched_wid];
         e_hit = m_busy_warp[rsp_wid];
         e_fv  = icache_rsp_valid && e_hit;
         e_rr  = e_hit ? fetch_ready : 1'b1;
      end
      check("sched_ready", 64'(sched_ready), 64'(e_rdy));
      check("req_valid", 64'(icache_req_valid), 64'(e_req));
      check("rsp_ready", 64'(icache_rsp_ready), 64'(e_rr));
      check("fetch_valid", 64'(fetch_valid), 64'(e_fv));
      check("busy", 64'(busy), 64'(e_busy));
      if (e_req) begin
         check("req_addr", 64'(icache_req_addr), 64'(sched_PC / 4));
         check("req_tag", 64'(icache_req_tag), 64'({sched_uuid, sched_wid}));
      end
      if (e_fv) begin
         check("fetch_uuid", 64'(fetch_uuid), 64'(rsp_uuid));
         check("fetch_wid", 64'(fetch_wid), 64'(rsp_wid));
         check("fetch_tmask", 64'(fetch_tmask), 64'(m_tm[rsp_wid]));
         check("fetch_PC", 64'(fetch_PC), 64'(m_pc[rsp_wid]));
         check("fetch_instr", 64'(fetch_instr), 64'(icache_rsp_data));
      end
      if (!reset) begin
`ifdef VX_FETCH_PERF_EN
         e_perf = m_perf;
`else
         e_perf = 0;
`endif
         check("perf", 64'(perf_stall_cycles), e_perf);
      end
      @(posedge clk);
      if (reset) begin
         foreach (m_busy_warp[i]) m_busy_warp[i] = 1'b0;
         m_perf = 0;
      end else begin
         if (e_fv && fetch_ready) m_busy_warp[rsp_wid] = 1'b0;
         if (sched_valid && e_rdy) begin
            m_busy_warp[sched_wid] = 1'b1;
            m_pc[sched_wid]        = sched_PC;
            m_tm[sched_wid]        = sched_tmask;
            m_uuid[sched_wid]      = sched_uuid;
         end
         if (sched_valid && !e_rdy && m_perf < ((64'd1 << PCB) - 1)) m_perf++;
      end
      #1;
   endtask

   task automatic idle();
      sched_valid = 0; icache_req_ready = 1; icache_rsp_valid = 0; fetch_ready = 1;
   endtask

   task automatic set_sched(input int w, input logic [UUID_WIDTH-1:0] u,
                            input logic [NUM_THREADS-1:0] tm, input logic [XLEN-1:0] pc);
      sched_valid = 1; sched_wid = NW_W'(w); sched_uuid = u; sched_tmask = tm; sched_PC = pc;
   endtask

   task automatic set_rsp(input int w, input logic [UUID_WIDTH-1:0] u, input logic [31:0] d);
      icache_rsp_valid = 1; rsp_wid = NW_W'(w); rsp_uuid = u; icache_rsp_data = d;
   endtask

   initial begin
      // Reset
      idle(); reset = 1;
      tick(); tick();
      reset = 0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_perf", 64'(perf_stall_cycles), 64'd0);

      // 1. single fetch
      set_sched(1, 44'h5, 4'hF, 32'h8000_0000);
      tick();
      idle(); set_rsp(1, 44'h5, 32'h0000_0013);
      #1;
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_valid", 64'(fetch_valid), 64'd1);
      check("t1_pc", 64'(fetch_PC), 64'h8000_0000);
      check("t1_tmask", 64'(fetch_tmask), 64'hF);
      check("t1_instr", 64'(fetch_instr), 64'h13);
      check("t1_wid", 64'(fetch_wid), 64'd1);
      tick();
      idle();
      #1;
      check("t1_busy_after", 64'(busy), 64'd0);

      // 2. out-of-order responses
      set_sched(0, 44'h10, 4'b0001, 32'h0000_0100); tick();
      set_sched(2, 44'h20, 4'b0110, 32'h0000_0200); tick();
      idle(); set_rsp(2, 44'h20, 32'hAAAA_0002);
      #1;
      check("t2_pc_w2", 64'(fetch_PC), 64'h200);
      check("t2_tm_w2", 64'(fetch_tmask), 64'h6);
      tick();
      set_rsp(0, 44'h10, 32'hAAAA_0000);
      #1;
      check("t2_pc_w0", 64'(fetch_PC), 64'h100);
      check("t2_tm_w0", 64'(fetch_tmask), 64'h1);
      tick();
      idle();

      // 3. same-warp hazard
      set_sched(3, 44'h30, 4'b1010, 32'h0000_0300); tick();
      set_sched(3, 44'h31, 4'b0101, 32'h0000_0304);
      #1;
      check("t3_blocked", 64'(sched_ready), 64'd0);
      tick(); tick();
      set_rsp(3, 44'h30, 32'h1111_1111);
      #1;
      check("t3_blocked_hs", 64'(sched_ready), 64'd0);
      tick();
      icache_rsp_valid = 0;
      #1;
      check("t3_ready_after", 64'(sched_ready), 64'd1);
      tick();
      idle(); set_rsp(3, 44'h31, 32'h2222_2222);
      #1;
      check("t3_second_pc", 64'(fetch_PC), 64'h304);
      tick();
      idle();

      // 4. decode backpressure
      set_sched(1, 44'h40, 4'b0011, 32'h0000_0400); tick();
      idle(); set_rsp(1, 44'h40, 32'hDEAD_BEEF); fetch_ready = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t4_rsp_ready", 64'(icache_rsp_ready), 64'd0);
         check("t4_hold_pc", 64'(fetch_PC), 64'h400);
         check("t4_hold_instr", 64'(fetch_instr), 64'hDEAD_BEEF);
         tick();
      end
      fetch_ready = 1;
      tick();
      idle();
      #1;
      check("t4_busy_after", 64'(busy), 64'd0);

      // 5. reset with two fetches in flight, then stale responses
      set_sched(0, 44'h50, 4'b1111, 32'h0000_0500); tick();
      set_sched(1, 44'h51, 4'b1111, 32'h0000_0504); tick();
      idle(); reset = 1; tick(); reset = 0;
      set_rsp(0, 44'h50, 32'h5555_0000);
      #1;
      check("t5_valid_w0", 64'(fetch_valid), 64'd0);
      check("t5_rr_w0", 64'(icache_rsp_ready), 64'd1);
      check("t5_busy", 64'(busy), 64'd0);
      tick();
      set_rsp(1, 44'h51, 32'h5555_0001);
      #1;
      check("t5_valid_w1", 64'(fetch_valid), 64'd0);
      tick();
      idle(); tick();

      // 6. stall counter
      set_sched(2, 44'h60, 4'b0001, 32'h0000_0600); icache_req_ready = 0;
      for (int i = 0; i < 7; i++) tick();
      idle();
      #1;
`ifdef VX_FETCH_PERF_EN
      check("t6_perf", 64'(perf_stall_cycles), 64'd7);
`else
      check("t6_perf", 64'(perf_stall_cycles), 64'd0);
`endif
      tick();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int q[$];
         logic [63:0] r64;
         r64 = {$urandom, $urandom};
         reset            = ($urandom_range(0, 299) == 0);
         sched_valid      = 1'($urandom_range(0, 1));
         sched_wid        = NW_W'($urandom_range(0, NUM_WARPS - 1));
         sched_uuid       = r64[UUID_WIDTH-1:0];
         sched_tmask      = NUM_THREADS'($urandom);
         sched_PC         = XLEN'($urandom) & ~XLEN'(3);
         icache_req_ready = ($urandom_range(0, 3) != 0);
         fetch_ready      = ($urandom_range(0, 9) < 7);
         icache_rsp_valid = 0;
         foreach (m_busy_warp[i]) if (m_busy_warp[i]) q.push_back(i);
         if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
            int w;
            w = q[$urandom_range(0, q.size() - 1)];
            set_rsp(w, m_uuid[w], $urandom);
         end
         tick();
      end
      reset = 0;
      idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
